draw_write_sched: RTL

- Owns the single write port of the draw framebuffer (the write side of the `clk`-domain SDP BRAM read by the VGA scan-out).
- Sequences each simulation frame in two phases:
  - a full-buffer clear sweep;
  - a plot phase that accepts pixel requests (x, y, data) from the fluid renderer over a valid/ready handshake.
- In the plot phase it converts coordinates to linear addresses, clips off-screen points and reports frame completion.
- Sits between the particle renderer and the `draw_addr_write` / `draw_data_in` / `draw_we` inputs of the draw/display block.

---
 rtl/draw_write_sched.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/draw_write_sched.sv
// Draw framebuffer write-port scheduler: clears the buffer, then writes the
// renderer's pixel requests (clipping off-screen points) and signals frame end.
module draw_write_sched #(
  parameter int DRAW_WIDTH  = 640,
  parameter int DRAW_HEIGHT = 480,
  parameter int DRAW_SIZE   = DRAW_WIDTH * DRAW_HEIGHT,
  parameter int DRAW_ADDRW  = $clog2(DRAW_SIZE),
  parameter int DRAW_DATAW  = 1,
  parameter logic [DRAW_DATAW-1:0] CLEAR_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic                  plot_valid,
  output logic                  plot_ready,
  input  logic [15:0]           plot_x,
  input  logic [15:0]           plot_y,
  input  logic [DRAW_DATAW-1:0] plot_data,
  input  logic                  plot_last,
  output logic                  busy,
  output logic                  frame_done,
  output logic [15:0]           clip_count,
  output logic [DRAW_ADDRW-1:0] draw_addr_write,
  output logic [DRAW_DATAW-1:0] draw_data_in,
  output logic                  draw_we
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_PLOT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [DRAW_ADDRW-1:0] r_cnt;
  logic [DRAW_ADDRW-1:0] w_cnt;
  logic                  r_we;
  logic                  w_we;
  logic [DRAW_ADDRW-1:0] r_addr;
  logic [DRAW_ADDRW-1:0] w_addr;
  logic [DRAW_DATAW-1:0] r_data;
  logic [DRAW_DATAW-1:0] w_data;
  logic                  r_done;
  logic                  w_done;
  logic [15:0]           r_clip;
  logic [15:0]           w_clip;
  logic                  w_hs;
  logic                  w_in_bounds;
  logic [DRAW_ADDRW-1:0] w_lin_addr;
  logic                  w_clear_last;

  assign plot_ready   = (r_state == S_PLOT);
  assign busy         = (r_state != S_IDLE);
  assign w_hs         = plot_valid & plot_ready;
  assign w_in_bounds  = ({16'd0, plot_x} < 32'(DRAW_WIDTH)) && ({16'd0, plot_y} < 32'(DRAW_HEIGHT));
  // Full 32-bit product before truncation so wide rows never alias early.
  assign w_lin_addr   = DRAW_ADDRW'(32'(plot_y) * 32'(DRAW_WIDTH) + 32'(plot_x));
  assign w_clear_last = (r_cnt == DRAW_ADDRW'(DRAW_SIZE - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = frame_start ? S_CLEAR : S_IDLE;
      S_CLEAR: w_next = w_clear_last ? S_PLOT : S_CLEAR;
      S_PLOT:  w_next = (w_hs && plot_last) ? S_DONE : S_PLOT;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_we   = 1'b0;
    w_addr = r_addr;
    w_data = r_data;
    w_cnt  = r_cnt;
    w_clip = r_clip;
    w_done = (r_state == S_PLOT) && w_hs && plot_last;
    case (r_state)
      S_IDLE: begin
        if (frame_start) begin
          w_cnt  = {DRAW_ADDRW{1'b0}};
          w_clip = 16'd0;
        end else begin
          w_cnt  = r_cnt;
        end
      end
      S_CLEAR: begin
        w_we   = 1'b1;
        w_addr = r_cnt;
        w_data = CLEAR_VAL;
        w_cnt  = r_cnt + DRAW_ADDRW'(1);
      end
      S_PLOT: begin
        if (w_hs && w_in_bounds) begin
          w_we   = 1'b1;
          w_addr = w_lin_addr;
          w_data = plot_data;
        end else if (w_hs) begin
          w_clip = (r_clip == 16'hFFFF) ? r_clip : r_clip + 16'd1;
        end else begin
          w_we   = 1'b0;
        end
      end
      S_DONE:  w_we = 1'b0;
      default: w_we = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= {DRAW_ADDRW{1'b0}};
      r_we   <= 1'b0;
      r_addr <= {DRAW_ADDRW{1'b0}};
      r_data <= {DRAW_DATAW{1'b0}};
      r_done <= 1'b0;
      r_clip <= 16'd0;
    end else begin
      r_cnt  <= w_cnt;
      r_we   <= w_we;
      r_addr <= w_addr;
      r_data <= w_data;
      r_done <= w_done;
      r_clip <= w_clip;
    end
  end

  assign draw_we         = r_we;
  assign draw_addr_write = r_addr;
  assign draw_data_in    = r_data;
  assign frame_done      = r_done;
  assign clip_count      = r_clip;

endmodule
